// File: rtl/des_req_arbiter.sv
// des_req_arbiter
// Shares one DES core between two requesters. Jobs are granted round-robin
// (at most one per cycle), registered onto the core inputs, and tagged with
// the requester ID in an in-order tag FIFO. Core results pop that FIFO and
// are routed back to the requester that issued the job.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready          per-requester job handshake (N = 0, 1)
//   reqN_key/text/encrypt     per-requester job payload
//   resp0_valid, resp1_valid  one-cycle pulse marking the owner of resp_data
//   resp_data                 registered core result, shared by both requesters
//   core_valid_in/key/text/encrypt_decrypt  registered job issue to the core
//   core_rstn                 core reset, ~rst (combinational)
//   core_cipher_text, core_valid_out        core result inputs
//   outstanding               tag FIFO occupancy
//   err_orphan                sticky: core result arrived with empty tag FIFO
module des_req_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [63:0]      req0_key,
  input  logic [63:0]      req0_text,
  input  logic             req0_encrypt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [63:0]      req1_key,
  input  logic [63:0]      req1_text,
  input  logic             req1_encrypt,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [63:0]      resp_data,
  output logic             core_valid_in,
  output logic [63:0]      core_key,
  output logic [63:0]      core_text,
  output logic             core_encrypt_decrypt,
  output logic             core_rstn,
  input  logic [63:0]      core_cipher_text,
  input  logic             core_valid_out,
  output logic [CNT_W-1:0] outstanding,
  output logic             err_orphan
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);

  logic                       last_grant_q, last_grant_d;
  logic [MAX_OUTSTANDING-1:0] tag_mem_q, tag_mem_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       core_valid_in_q, core_valid_in_d;
  logic [63:0]                core_key_q, core_key_d;
  logic [63:0]                core_text_q, core_text_d;
  logic                       core_enc_q, core_enc_d;
  logic                       resp0_valid_q, resp0_valid_d;
  logic                       resp1_valid_q, resp1_valid_d;
  logic [63:0]                resp_data_q, resp_data_d;
  logic                       err_orphan_q, err_orphan_d;

  logic full, empty;
  logic grant0, grant1;
  logic acc0, acc1, accept, pop;

  assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);

  // Round-robin: on a tie the requester that did not win last gets the grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant_q;
      grant1 = ~last_grant_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Fullness uses the registered count, so a same-cycle pop never frees a slot.
  assign req0_ready = grant0 && !full && !rst;
  assign req1_ready = grant1 && !full && !rst;

  assign acc0   = req0_valid && req0_ready;
  assign acc1   = req1_valid && req1_ready;
  assign accept = acc0 || acc1;
  assign pop    = core_valid_out && !empty;

  always_comb begin
    last_grant_d    = last_grant_q;
    tag_mem_d       = tag_mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    core_valid_in_d = 1'b0;
    core_key_d      = core_key_q;
    core_text_d     = core_text_q;
    core_enc_d      = core_enc_q;
    resp0_valid_d   = 1'b0;
    resp1_valid_d   = 1'b0;
    resp_data_d     = resp_data_q;
    err_orphan_d    = err_orphan_q;

    if (accept) begin
      last_grant_d        = acc1;
      tag_mem_d[wr_ptr_q] = acc1;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      core_valid_in_d     = 1'b1;
      core_key_d          = acc1 ? req1_key     : req0_key;
      core_text_d         = acc1 ? req1_text    : req0_text;
      core_enc_d          = acc1 ? req1_encrypt : req0_encrypt;
    end

    if (core_valid_out) begin
      if (pop) begin
        rd_ptr_d      = rd_ptr_q + PTR_W'(1);
        resp0_valid_d = ~tag_mem_q[rd_ptr_q];
        resp1_valid_d = tag_mem_q[rd_ptr_q];
        resp_data_d   = core_cipher_text;
      end else begin
        err_orphan_d  = 1'b1;
      end
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q    <= 1'b1;
      tag_mem_q       <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      core_valid_in_q <= 1'b0;
      core_key_q      <= '0;
      core_text_q     <= '0;
      core_enc_q      <= 1'b0;
      resp0_valid_q   <= 1'b0;
      resp1_valid_q   <= 1'b0;
      resp_data_q     <= '0;
      err_orphan_q    <= 1'b0;
    end else begin
      last_grant_q    <= last_grant_d;
      tag_mem_q       <= tag_mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      core_valid_in_q <= core_valid_in_d;
      core_key_q      <= core_key_d;
      core_text_q     <= core_text_d;
      core_enc_q      <= core_enc_d;
      resp0_valid_q   <= resp0_valid_d;
      resp1_valid_q   <= resp1_valid_d;
      resp_data_q     <= resp_data_d;
      err_orphan_q    <= err_orphan_d;
    end
  end

  assign resp0_valid          = resp0_valid_q;
  assign resp1_valid          = resp1_valid_q;
  assign resp_data            = resp_data_q;
  assign core_valid_in        = core_valid_in_q;
  assign core_key             = core_key_q;
  assign core_text            = core_text_q;
  assign core_encrypt_decrypt = core_enc_q;
  assign core_rstn            = ~rst;
  assign outstanding          = count_q;
  assign err_orphan           = err_orphan_q;

endmodule

// File: tb/tb_des_req_arbiter.sv
// tb_des_req_arbiter
// Directed bench for des_req_arbiter with a stub DES core driven by the bench.
// Accepted jobs are pushed to an expected core-issue queue and a tag model;
// stub core results push expected responses; a negedge monitor pops both.
module tb_des_req_arbiter;

  localparam int unsigned MAXO = 16;
  localparam int unsigned CW   = $clog2(MAXO) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req0_encrypt;
  logic [63:0]   req0_key, req0_text;
  logic          req1_valid, req1_ready, req1_encrypt;
  logic [63:0]   req1_key, req1_text;
  logic          resp0_valid, resp1_valid;
  logic [63:0]   resp_data;
  logic          core_valid_in, core_encrypt_decrypt, core_rstn;
  logic [63:0]   core_key, core_text;
  logic [63:0]   core_cipher_text;
  logic          core_valid_out;
  logic [CW-1:0] outstanding;
  logic          err_orphan;

  des_req_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key),
    .req0_text(req0_text), .req0_encrypt(req0_encrypt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key),
    .req1_text(req1_text), .req1_encrypt(req1_encrypt),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_data(resp_data),
    .core_valid_in(core_valid_in), .core_key(core_key), .core_text(core_text),
    .core_encrypt_decrypt(core_encrypt_decrypt), .core_rstn(core_rstn),
    .core_cipher_text(core_cipher_text), .core_valid_out(core_valid_out),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] key;
    logic [63:0] text;
    logic        enc;
  } job_t;

  typedef struct {
    logic        id;
    logic [63:0] data;
  } resp_t;

  int checks = 0;
  int failures = 0;

  job_t        core_q[$];
  resp_t       resp_q[$];
  logic        tag_q[$];
  logic [63:0] last_resp = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic job_t rnd_job();
    job_t j;
    j.key  = {$urandom, $urandom};
    j.text = {$urandom, $urandom};
    j.enc  = 1'($urandom_range(0, 1));
    return j;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock: drive inputs, check readies, clock, then record what the
  // bench expects the DUT to have accepted / popped on that edge.
  task automatic cycle(input logic v0, input logic v1, input logic e0, input logic e1,
                       input logic cvo, input logic [63:0] cdata,
                       input job_t j0, input job_t j1);
    logic pop;
    logic id;
    req0_valid = v0; req0_key = j0.key; req0_text = j0.text; req0_encrypt = j0.enc;
    req1_valid = v1; req1_key = j1.key; req1_text = j1.text; req1_encrypt = j1.enc;
    core_valid_out   = cvo;
    core_cipher_text = cdata;
    #1;
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    pop = cvo && (tag_q.size() != 0);
    step();
    if (pop) begin
      id = tag_q.pop_front();
      resp_q.push_back('{id: id, data: cdata});
      last_resp = cdata;
    end
    if (v0 && e0) begin core_q.push_back(j0); tag_q.push_back(1'b0); end
    if (v1 && e1) begin core_q.push_back(j1); tag_q.push_back(1'b1); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    core_valid_out = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    job_t  j;
    resp_t r;
    if (core_valid_in === 1'b1) begin
      if (core_q.size() == 0) chk("core_valid_in_unexpected", core_valid_in, 1'b0);
      else begin
        j = core_q.pop_front();
        chk("core_key", core_key, j.key);
        chk("core_text", core_text, j.text);
        chk("core_encrypt_decrypt", core_encrypt_decrypt, j.enc);
      end
    end
    if (resp0_valid === 1'b1 || resp1_valid === 1'b1) begin
      if (resp_q.size() == 0) chk("resp_unexpected", {resp1_valid, resp0_valid}, 2'b00);
      else begin
        r = resp_q.pop_front();
        chk("resp_route", {resp1_valid, resp0_valid}, r.id ? 2'b10 : 2'b01);
        chk("resp_data", resp_data, r.data);
      end
    end
  end

  initial begin
    job_t        sj;
    logic [63:0] d;

    sj.key = 64'h133457799BBCDFF1;
    sj.text = 64'h0123456789ABCDEF;
    sj.enc = 1'b1;

    rst = 1'b1;
    req0_valid = 1'b1; req0_key = sj.key; req0_text = sj.text; req0_encrypt = sj.enc;
    req1_valid = 1'b0; req1_key = '0; req1_text = '0; req1_encrypt = 1'b0;
    core_valid_out = 1'b0; core_cipher_text = '0;

    // Reset held three cycles with req0 asking.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_req0_ready", req0_ready, 1'b0);
      chk("rst_core_valid_in", core_valid_in, 1'b0);
      chk("rst_outstanding", outstanding, '0);
      chk("rst_err_orphan", err_orphan, 1'b0);
      chk("rst_core_rstn", core_rstn, 1'b0);
      chk("rst_resp_valid", {resp1_valid, resp0_valid}, 2'b00);
    end
    rst = 1'b0;

    // Single job, ready rises the cycle reset releases.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, sj, rnd_job());
    chk("core_rstn_run", core_rstn, 1'b1);
    chk("single_core_valid_in", core_valid_in, 1'b1);
    chk("single_outstanding", outstanding, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h85E813540F0AB405, rnd_job(), rnd_job());
    chk("single_resp0_valid", resp0_valid, 1'b1);
    chk("single_resp1_valid", resp1_valid, 1'b0);
    chk("single_resp_data", resp_data, 64'h85E813540F0AB405);
    chk("single_outstanding_back", outstanding, 0);
    step();
    chk("single_resp_pulse_end", resp0_valid, 1'b0);

    // Lone requester 1 job, routes to resp1.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, rnd_job(), rnd_job());
    d = {$urandom, $urandom};
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d, rnd_job(), rnd_job());
    chk("solo1_resp1_valid", resp1_valid, 1'b1);
    chk("solo1_resp0_valid", resp0_valid, 1'b0);

    // Contention: last winner was 1, so grants go 0,1,0,1,0,1.
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 1'b1, (i % 2) == 0, (i % 2) == 1, 1'b0, '0, rnd_job(), rnd_job());
    chk("contend_outstanding", outstanding, 6);
    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom};
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d, rnd_job(), rnd_job());
    end
    step();
    chk("contend_drained", outstanding, 0);
    chk("contend_resp_q_empty", resp_q.size(), 0);

    // Fill the tag FIFO with a non-returning core.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, rnd_job(), rnd_job());
      chk("fill_outstanding", outstanding, 64'(i + 1));
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, rnd_job(), rnd_job());
    chk("full_outstanding", outstanding, MAXO);
    d = {$urandom, $urandom};
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, d, rnd_job(), rnd_job());
    chk("full_pop_outstanding", outstanding, MAXO - 1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, rnd_job(), rnd_job());
    chk("full_refill_outstanding", outstanding, MAXO);
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d, rnd_job(), rnd_job());
    end
    step();
    chk("full_drained", outstanding, 0);
    chk("full_resp_q_empty", resp_q.size(), 0);
    chk("no_orphan_yet", err_orphan, 1'b0);

    // Orphan result with empty FIFO.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hAAAAAAAAAAAAAAAA, rnd_job(), rnd_job());
    chk("orphan_set", err_orphan, 1'b1);
    chk("orphan_no_resp", {resp1_valid, resp0_valid}, 2'b00);
    chk("orphan_resp_data_held", resp_data, last_resp);
    chk("orphan_outstanding", outstanding, 0);
    repeat (3) step();
    chk("orphan_sticky", err_orphan, 1'b1);

    // Reset with three jobs in flight.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, rnd_job(), rnd_job());
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, rnd_job(), rnd_job());
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, rnd_job(), rnd_job());
    step();
    chk("midflight_outstanding", outstanding, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    tag_q.delete();
    chk("midflight_rst_outstanding", outstanding, 0);
    chk("midflight_rst_err_clear", err_orphan, 1'b0);
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d, rnd_job(), rnd_job());
    end
    chk("midflight_err_orphan", err_orphan, 1'b1);
    chk("midflight_outstanding_zero", outstanding, 0);
    step();
    chk("end_core_q_empty", core_q.size(), 0);
    chk("end_resp_q_empty", resp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
